// File: rtl/mmio_input_ctrl.sv
// Memory-mapped KEY/SW responder: two-flop sync, per-bit debounce, sticky key-press
// events with W1C clear, KEY[0] press counter and a registered interrupt.
module mmio_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned N_KEY           = 4,
    parameter int unsigned N_SW            = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      writedata,
    input  logic             memwrite,
    output logic [31:0]      readdata,
    input  logic [N_KEY-1:0] KEY,
    input  logic [N_SW-1:0]  SW,
    output logic [N_KEY-1:0] key_pressed,
    output logic             irq
);

    localparam int unsigned N_IN  = N_KEY + N_SW;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Keys and switches share one vector, keys in the low bits, all active-high.
    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  sync1_q, sync2_q;
    logic [N_IN-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] dcnt_q [N_IN];
    logic [CNT_W-1:0] dcnt_d [N_IN];
    logic [N_KEY-1:0] event_q, event_d;
    logic [7:0]       press_q, press_d;
    logic             irq_q, irq_d;

    logic             sel_key, sel_sw, sel_evt, sel_cnt;
    logic [N_KEY-1:0] key_rise, evt_clr;
    logic             unused_bits;

    assign raw         = {SW, ~KEY};
    assign unused_bits = ^{addr[31:9], addr[3:0], writedata[31:N_KEY]};

    // Window decode: lowest select bit wins when several are set.
    always_comb begin
        sel_key = 1'b0;
        sel_sw  = 1'b0;
        sel_evt = 1'b0;
        sel_cnt = 1'b0;
        if (addr[8]) begin
            if (addr[4])      sel_key = 1'b1;
            else if (addr[5]) sel_sw  = 1'b1;
            else if (addr[6]) sel_evt = 1'b1;
            else if (addr[7]) sel_cnt = 1'b1;
        end
    end

    always_comb begin
        readdata = 32'h0;
        if (sel_key)      readdata = 32'(stable_q[N_KEY-1:0]);
        else if (sel_sw)  readdata = 32'(stable_q[N_IN-1:N_KEY]);
        else if (sel_evt) readdata = 32'(event_q);
        else if (sel_cnt) readdata = 32'(press_q);
    end

    // Debounce: flip after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(N_IN); i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (dcnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
                else                       dcnt_d[i]   = dcnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Events and counter: a press on the same edge as a clear always survives.
    always_comb begin
        key_rise = stable_d[N_KEY-1:0] & ~stable_q[N_KEY-1:0];
        evt_clr  = (memwrite && sel_evt) ? writedata[N_KEY-1:0] : '0;
        event_d  = (event_q & ~evt_clr) | key_rise;
        press_d  = (memwrite && sel_cnt) ? 8'h0 : press_q;
        if (key_rise[0]) press_d = press_d + 8'h1;
        irq_d    = |event_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            event_q  <= '0;
            press_q  <= 8'h0;
            irq_q    <= 1'b0;
            for (int i = 0; i < int'(N_IN); i++) dcnt_q[i] <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            event_q  <= event_d;
            press_q  <= press_d;
            irq_q    <= irq_d;
            for (int i = 0; i < int'(N_IN); i++) dcnt_q[i] <= dcnt_d[i];
        end
    end

    assign key_pressed = stable_q[N_KEY-1:0];
    assign irq         = irq_q;

endmodule
